// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: CSR storage, trap/mret state updates,
// mcycle/minstret counters, interrupt-pending decision and a one-cycle
// fetch redirect FSM.
module csr_regfile #(
    parameter int              XLEN     = 64,
    parameter int              HART_ID  = 0,
    parameter logic [XLEN-1:0] MISA_VAL = 64'h8000_0000_0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_raddr_i,
    input  logic            csr_rd_en_i,
    output logic [XLEN-1:0] csr_rdata_o,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_waddr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic            illegal_csr_o,
    input  logic            instr_retire_i,
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic            irq_pending_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o
);
    localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA   = 12'h301, A_MIE    = 12'h304,
                            A_MTVEC    = 12'h305, A_MSCR   = 12'h340, A_MEPC   = 12'h341,
                            A_MCAUSE   = 12'h342, A_MTVAL  = 12'h343, A_MIP    = 12'h344,
                            A_MCYCLE   = 12'hB00, A_MINSTR = 12'hB02, A_CYCLE  = 12'hC00,
                            A_INSTRET  = 12'hC02, A_HARTID = 12'hF14;

    typedef enum logic {IDLE, REDIR} state_t;
    state_t state;

    logic            mstatus_mie, mstatus_mpie, mie_mtie, mie_meie;
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret;
    logic [XLEN-1:0] mstatus_val, mie_val, mip_val;
    logic            rd_mapped, wr_illegal, wr_ok, trap_take, mret_take;

    function automatic logic is_mapped(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCR, A_MEPC, A_MCAUSE, A_MTVAL,
            A_MIP, A_MCYCLE, A_MINSTR, A_CYCLE, A_INSTRET, A_HARTID: is_mapped = 1'b1;
            default: is_mapped = 1'b0;
        endcase
    endfunction

    // Assemble the composite registers from their individual fields
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[3]     = mstatus_mie;
        mstatus_val[7]     = mstatus_mpie;
        mstatus_val[12:11] = 2'b11;
        mie_val            = '0;
        mie_val[7]         = mie_mtie;
        mie_val[11]        = mie_meie;
        mip_val            = '0;
        mip_val[7]         = irq_timer_i;
        mip_val[11]        = irq_ext_i;
    end

    // Combinational read mux; writes in the same cycle are not forwarded
    always_comb begin
        rd_mapped   = is_mapped(csr_raddr_i);
        csr_rdata_o = '0;
        case (csr_raddr_i)
            A_MSTATUS:           csr_rdata_o = mstatus_val;
            A_MISA:              csr_rdata_o = MISA_VAL;
            A_MIE:               csr_rdata_o = mie_val;
            A_MTVEC:             csr_rdata_o = mtvec;
            A_MSCR:              csr_rdata_o = mscratch;
            A_MEPC:              csr_rdata_o = mepc;
            A_MCAUSE:            csr_rdata_o = mcause;
            A_MTVAL:             csr_rdata_o = mtval;
            A_MIP:               csr_rdata_o = mip_val;
            A_MCYCLE, A_CYCLE:   csr_rdata_o = mcycle;
            A_MINSTR, A_INSTRET: csr_rdata_o = minstret;
            A_HARTID:            csr_rdata_o = XLEN'(HART_ID);
            default:             csr_rdata_o = '0;
        endcase
    end

    // Legality and event priority: trap > mret > CSR write, all ignored in REDIR
    always_comb begin
        wr_illegal    = ~is_mapped(csr_waddr_i) | (csr_waddr_i[11:10] == 2'b11)
                      | (csr_waddr_i == A_MISA) | (csr_waddr_i == A_MIP);
        illegal_csr_o = (csr_rd_en_i & ~rd_mapped) | (csr_we_i & wr_illegal);
        trap_take     = (state == IDLE) & trap_req_i;
        mret_take     = (state == IDLE) & ~trap_req_i & mret_i;
        wr_ok         = (state == IDLE) & ~trap_req_i & ~mret_i & csr_we_i & ~wr_illegal;
        irq_pending_o = (state == IDLE) & mstatus_mie
                      & ((mie_meie & irq_ext_i) | (mie_mtie & irq_timer_i));
    end

    // CSR state: trap entry, mret, then software writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mtvec        <= '0;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
        end else if (trap_take) begin
            mepc         <= trap_pc_i & ~XLEN'(3);
            mcause       <= trap_cause_i;
            mtval        <= trap_val_i;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_take) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (wr_ok) begin
            case (csr_waddr_i)
                A_MSTATUS: begin
                    mstatus_mie  <= csr_wdata_i[3];
                    mstatus_mpie <= csr_wdata_i[7];
                end
                A_MIE: begin
                    mie_mtie <= csr_wdata_i[7];
                    mie_meie <= csr_wdata_i[11];
                end
                A_MTVEC:  mtvec    <= csr_wdata_i & ~XLEN'(3);
                A_MSCR:   mscratch <= csr_wdata_i;
                A_MEPC:   mepc     <= csr_wdata_i & ~XLEN'(3);
                A_MCAUSE: mcause   <= csr_wdata_i;
                A_MTVAL:  mtval    <= csr_wdata_i;
                default: ;
            endcase
        end
    end

    // Free-running counters; an accepted CSR write overrides the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_ok && csr_waddr_i == A_MCYCLE) mcycle <= csr_wdata_i;
            else                                  mcycle <= mcycle + 1'b1;
            if (wr_ok && csr_waddr_i == A_MINSTR) minstret <= csr_wdata_i;
            else if (instr_retire_i)              minstret <= minstret + 1'b1;
        end
    end

    // Redirect FSM: one-cycle pulse toward mtvec (trap) or mepc (mret)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_take || mret_take) begin
                        state         <= REDIR;
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= trap_take ? mtvec : mepc;
                    end
                end
                REDIR: begin
                    state         <= IDLE;
                    redirect_o    <= 1'b0;
                    redirect_pc_o <= '0;
                end
                default: begin
                    state      <= IDLE;
                    redirect_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csr_regfile.sv
// Directed testbench for csr_regfile with hand-computed expectations.
module tb_csr_regfile;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [11:0]     csr_raddr_i, csr_waddr_i;
    logic            csr_rd_en_i, csr_we_i;
    logic [XLEN-1:0] csr_rdata_o, csr_wdata_i;
    logic            illegal_csr_o, instr_retire_i, trap_req_i, mret_i;
    logic [XLEN-1:0] trap_cause_i, trap_pc_i, trap_val_i, redirect_pc_o;
    logic            irq_timer_i, irq_ext_i, irq_pending_o, redirect_o;

    int n_tests = 0;
    int n_fail  = 0;

    csr_regfile dut (
        .clk(clk), .rst(rst),
        .csr_raddr_i(csr_raddr_i), .csr_rd_en_i(csr_rd_en_i), .csr_rdata_o(csr_rdata_o),
        .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
        .illegal_csr_o(illegal_csr_o), .instr_retire_i(instr_retire_i),
        .trap_req_i(trap_req_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
        .trap_val_i(trap_val_i), .mret_i(mret_i), .irq_timer_i(irq_timer_i),
        .irq_ext_i(irq_ext_i), .irq_pending_o(irq_pending_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [XLEN-1:0] d);
        csr_we_i = 1'b1; csr_waddr_i = a; csr_wdata_i = d;
        tick();
        csr_we_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [XLEN-1:0] exp);
        csr_rd_en_i = 1'b1; csr_raddr_i = a;
        #1;
        chk(tag, csr_rdata_o, exp);
        csr_rd_en_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        csr_raddr_i = '0; csr_waddr_i = '0; csr_rd_en_i = 1'b0; csr_we_i = 1'b0;
        csr_wdata_i = '0; instr_retire_i = 1'b0; trap_req_i = 1'b0; mret_i = 1'b0;
        trap_cause_i = '0; trap_pc_i = '0; trap_val_i = '0;
        irq_timer_i = 1'b0; irq_ext_i = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset values and cycle counter
        chk("rst_redirect", {63'd0, redirect_o}, 64'd0);
        chk("rst_redirect_pc", redirect_pc_o, 64'd0);
        rd("rst_mstatus", 12'h300, 64'h1800);
        rd("rst_mscratch", 12'h340, 64'h0);
        repeat (5) tick();
        rd("mcycle_5", 12'hB00, 64'd5);
        rd("misa", 12'h301, 64'h8000_0000_0000_0100);
        rd("mhartid", 12'hF14, 64'h0);

        // 2: trap entry
        wr(12'h305, 64'h8000_0003);
        wr(12'h300, 64'h8);
        rd("mtvec_mask", 12'h305, 64'h8000_0000);
        trap_req_i = 1'b1; trap_cause_i = 64'd2; trap_pc_i = 64'h1006; trap_val_i = 64'h55;
        tick();
        trap_req_i = 1'b0;
        chk("trap_redirect", {63'd0, redirect_o}, 64'd1);
        chk("trap_target", redirect_pc_o, 64'h8000_0000);
        tick();
        chk("trap_pulse_end", {63'd0, redirect_o}, 64'd0);
        rd("mepc", 12'h341, 64'h1004);
        rd("mcause", 12'h342, 64'd2);
        rd("mtval", 12'h343, 64'h55);
        rd("mstatus_trap", 12'h300, 64'h1880);

        // 3: mret
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        chk("mret_redirect", {63'd0, redirect_o}, 64'd1);
        chk("mret_target", redirect_pc_o, 64'h1004);
        tick();
        rd("mstatus_mret", 12'h300, 64'h1888);

        // 4: trap beats CSR write; trap during REDIR ignored
        wr(12'h340, 64'hAAAA);
        trap_req_i = 1'b1; trap_cause_i = 64'd3; trap_pc_i = 64'h2000;
        csr_we_i = 1'b1; csr_waddr_i = 12'h340; csr_wdata_i = 64'h5555;
        tick();
        csr_we_i = 1'b0;
        chk("trap4_redirect", {63'd0, redirect_o}, 64'd1);
        trap_cause_i = 64'd7; trap_pc_i = 64'h3000;
        tick();
        trap_req_i = 1'b0;
        chk("no_second_pulse", {63'd0, redirect_o}, 64'd0);
        rd("mscratch_kept", 12'h340, 64'hAAAA);
        rd("mcause_first", 12'h342, 64'd3);
        rd("mepc_first", 12'h341, 64'h2000);

        // 5: illegal accesses
        wr(12'hB00, 64'd1000);
        csr_we_i = 1'b1; csr_waddr_i = 12'hC00; csr_wdata_i = 64'd0;
        #1 chk("ill_c00", {63'd0, illegal_csr_o}, 64'd1);
        tick();
        csr_we_i = 1'b0;
        rd("cycle_alias", 12'hC00, 64'd1001);
        rd("mcycle_kept", 12'hB00, 64'd1001);
        csr_we_i = 1'b1; csr_waddr_i = 12'h344; csr_wdata_i = '1;
        #1 chk("ill_mip", {63'd0, illegal_csr_o}, 64'd1);
        tick();
        csr_we_i = 1'b1; csr_waddr_i = 12'h7C0;
        #1 chk("ill_7c0", {63'd0, illegal_csr_o}, 64'd1);
        csr_waddr_i = 12'h301;
        #1 chk("ill_misa", {63'd0, illegal_csr_o}, 64'd1);
        csr_waddr_i = 12'h340;
        #1 chk("legal_wr", {63'd0, illegal_csr_o}, 64'd0);
        csr_we_i = 1'b0;
        rd("mip_unchanged", 12'h344, 64'h0);
        csr_rd_en_i = 1'b1; csr_raddr_i = 12'h123;
        #1;
        chk("unmapped_rdata", csr_rdata_o, 64'h0);
        chk("unmapped_ill", {63'd0, illegal_csr_o}, 64'd1);
        csr_rd_en_i = 1'b0;
        #1 chk("unqualified_rd", {63'd0, illegal_csr_o}, 64'd0);

        // 6: interrupt pending and minstret wrap
        wr(12'h300, 64'h8);
        wr(12'h304, 64'hFFFF);
        rd("mie_mask", 12'h304, 64'h880);
        wr(12'h304, 64'h80);
        irq_timer_i = 1'b1;
        #1 chk("irq_timer", {63'd0, irq_pending_o}, 64'd1);
        rd("mip_timer", 12'h344, 64'h80);
        irq_ext_i = 1'b1;
        rd("mip_both", 12'h344, 64'h880);
        wr(12'h304, 64'h0);
        #1 chk("irq_masked", {63'd0, irq_pending_o}, 64'd0);
        irq_timer_i = 1'b0; irq_ext_i = 1'b0;
        csr_we_i = 1'b1; csr_waddr_i = 12'hB02; csr_wdata_i = '1; instr_retire_i = 1'b1;
        tick();
        csr_we_i = 1'b0;
        rd("minstret_wr_wins", 12'hC02, '1);
        tick();
        instr_retire_i = 1'b0;
        rd("minstret_wrap", 12'hB02, 64'h0);

        // async reset mid-REDIR aborts the pulse
        trap_req_i = 1'b1;
        tick();
        trap_req_i = 1'b0;
        chk("pre_abort", {63'd0, redirect_o}, 64'd1);
        rst = 1'b1;
        #1 chk("abort_redirect", {63'd0, redirect_o}, 64'd0);
        rd("abort_mstatus", 12'h300, 64'h1800);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
